// File: rtl/syscall_ctrl.sv
// syscall_ctrl: services MIPS syscall by borrowing the register file
// and driving a valid/ready console (print int/char, read int, exit).
module syscall_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syscall,
  output logic              stall,
  output logic              rf_sel,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_char,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              halted,
  output logic              bad_code,
  output logic [DATA_W-1:0] bad_code_val
);

  typedef enum logic [3:0] {
    IDLE,
    RD_V0,
    RD_A0,
    DISPATCH,
    PRINT,
    READ,
    WRITE,
    DONE,
    HALT
  } state_t;

  localparam logic [ADDR_W-1:0] REG_V0 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] REG_A0 = ADDR_W'(4);

  state_t state, nxt;

  logic [DATA_W-1:0] v0, a0, rd_val;
  logic is_int, is_chr, is_rd, is_exit;

  assign is_int  = (v0 == DATA_W'(1));
  assign is_chr  = (v0 == DATA_W'(11));
  assign is_rd   = (v0 == DATA_W'(5));
  assign is_exit = (v0 == DATA_W'(10));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      v0           <= '0;
      a0           <= '0;
      rd_val       <= '0;
      bad_code     <= 1'b0;
      bad_code_val <= '0;
    end else begin
      state <= nxt;
      if (state == RD_A0)
        v0 <= rf_rd_data;
      if (state == DISPATCH)
        a0 <= rf_rd_data;
      if (state == READ && in_valid)
        rd_val <= in_data;
      if (state == DISPATCH &&
          !(is_int || is_chr || is_rd || is_exit)) begin
        bad_code     <= 1'b1;
        bad_code_val <= v0;
      end
    end
  end

  always_comb begin
    nxt        = state;
    stall      = 1'b1;
    rf_sel     = 1'b0;
    rf_rd_addr = '0;
    rf_we      = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_char   = 1'b0;
    in_ready   = 1'b0;
    halted     = 1'b0;
    unique case (state)
      IDLE: begin
        stall = syscall;
        if (syscall)
          nxt = RD_V0;
      end
      RD_V0: begin
        rf_sel     = 1'b1;
        rf_rd_addr = REG_V0;
        nxt        = RD_A0;
      end
      RD_A0: begin
        rf_sel     = 1'b1;
        rf_rd_addr = REG_A0;
        nxt        = DISPATCH;
      end
      DISPATCH: begin
        rf_sel = 1'b1;
        unique case (1'b1)
          is_int, is_chr: nxt = PRINT;
          is_rd:          nxt = READ;
          is_exit:        nxt = HALT;
          default:        nxt = DONE;
        endcase
      end
      PRINT: begin
        out_valid = 1'b1;
        out_data  = a0;
        out_char  = is_chr;
        if (out_ready)
          nxt = DONE;
      end
      READ: begin
        in_ready = 1'b1;
        if (in_valid)
          nxt = WRITE;
      end
      WRITE: begin
        rf_sel     = 1'b1;
        rf_we      = 1'b1;
        rf_wr_addr = REG_V0;
        rf_wr_data = rd_val;
        nxt        = DONE;
      end
      DONE:
        nxt = IDLE;
      HALT:
        halted = 1'b1;
      default:
        nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_ctrl.sv
// tb_syscall_ctrl: directed vectors for syscall_ctrl with a tiny
// register-file model holding $v0/$a0.
module tb_syscall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall;
  logic        stall;
  logic        rf_sel;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_char;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        halted;
  logic        bad_code;
  logic [31:0] bad_code_val;

  int checks = 0;
  int failures = 0;

  logic [31:0] r2, r4;
  int n_out = 0;
  int n_we = 0;
  logic [4:0]  last_wa;
  logic [31:0] last_wd;
  int o0, w0;

  always #5 clk = ~clk;

  syscall_ctrl dut (
    .clk(clk), .reset(reset), .syscall(syscall),
    .stall(stall), .rf_sel(rf_sel),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_char(out_char),
    .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .halted(halted),
    .bad_code(bad_code), .bad_code_val(bad_code_val)
  );

  // registered read port: data for an address appears next cycle
  always @(posedge clk) begin
    rf_rd_data <= (rf_rd_addr == 5'd2) ? r2 :
                  (rf_rd_addr == 5'd4) ? r4 : 32'd0;
    if (!reset) begin
      if (out_valid && out_ready) n_out <= n_out + 1;
      if (rf_we) begin
        n_we    <= n_we + 1;
        last_wa <= rf_wr_addr;
        last_wd <= rf_wr_data;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issues syscall in c0 and walks to the start of c4
  task automatic run_sys(input string tag);
    syscall = 1'b1;
    #1;
    chk({tag, ".c0_stall"}, stall, 1);
    tick();
    syscall = 1'b0;
    chk({tag, ".c1_sel"}, rf_sel, 1);
    chk({tag, ".c1_addr"}, rf_rd_addr, 2);
    tick();
    chk({tag, ".c2_addr"}, rf_rd_addr, 4);
    tick();
    chk({tag, ".c3_sel"}, rf_sel, 1);
    chk({tag, ".c3_ov"}, out_valid, 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; syscall = 1'b0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    r2 = '0; r4 = '0;
    tick();
    tick();
    chk("rst.stall", stall, 0);
    chk("rst.sel", rf_sel, 0);
    chk("rst.ov", out_valid, 0);
    chk("rst.halted", halted, 0);
    chk("rst.bad", bad_code, 0);
    chk("rst.rdaddr", rf_rd_addr, 0);
    chk("rst.badval", bad_code_val, 0);
    reset = 1'b0;
    tick();

    // print int, ready tied high
    r2 = 32'd1; r4 = 32'hFFFF_FFF9; out_ready = 1'b1;
    o0 = n_out; w0 = n_we;
    run_sys("pi");
    chk("pi.c4_ov", out_valid, 1);
    chk("pi.c4_data", out_data, 32'hFFFF_FFF9);
    chk("pi.c4_char", out_char, 0);
    chk("pi.c4_stall", stall, 1);
    tick();
    chk("pi.c5_ov", out_valid, 0);
    chk("pi.c5_stall", stall, 1);
    tick();
    chk("pi.c6_stall", stall, 0);
    chk("pi.xfers", n_out - o0, 1);
    chk("pi.we", n_we - w0, 0);

    // print char, ready low for 3 cycles
    r2 = 32'd11; r4 = 32'h141; out_ready = 1'b0;
    o0 = n_out;
    run_sys("pc");
    for (int i = 0; i < 3; i++) begin
      chk("pc.ov", out_valid, 1);
      chk("pc.data", out_data, 32'h141);
      chk("pc.char", out_char, 1);
      tick();
    end
    out_ready = 1'b1;
    chk("pc.ov4", out_valid, 1);
    chk("pc.data4", out_data, 32'h141);
    tick();
    chk("pc.done_ov", out_valid, 0);
    tick();
    chk("pc.stall", stall, 0);
    chk("pc.xfers", n_out - o0, 1);

    // read int, input arrives after 2 cycles
    r2 = 32'd5; r4 = 32'd0;
    w0 = n_we;
    run_sys("rd");
    chk("rd.c4_inrdy", in_ready, 1);
    tick();
    chk("rd.c5_inrdy", in_ready, 1);
    chk("rd.c5_we", rf_we, 0);
    tick();
    in_valid = 1'b1; in_data = 32'd42;
    chk("rd.n_inrdy", in_ready, 1);
    tick();
    in_valid = 1'b0; in_data = 32'd0;
    chk("rd.n1_we", rf_we, 1);
    chk("rd.n1_wa", rf_wr_addr, 2);
    chk("rd.n1_wd", rf_wr_data, 42);
    chk("rd.n1_inrdy", in_ready, 0);
    tick();
    chk("rd.n2_we", rf_we, 0);
    chk("rd.n2_stall", stall, 1);
    tick();
    chk("rd.n3_stall", stall, 0);
    chk("rd.we_cnt", n_we - w0, 1);
    chk("rd.wa", last_wa, 2);
    chk("rd.wd", last_wd, 42);
    r4 = last_wd; r2 = 32'd1; out_ready = 1'b1;
    run_sys("rp");
    chk("rp.ov", out_valid, 1);
    chk("rp.data", out_data, 42);
    tick();
    tick();

    // unsupported code
    r2 = 32'd7; o0 = n_out;
    run_sys("bc");
    chk("bc.c4_bad", bad_code, 1);
    chk("bc.c4_val", bad_code_val, 7);
    chk("bc.c4_ov", out_valid, 0);
    chk("bc.c4_stall", stall, 1);
    tick();
    chk("bc.c5_stall", stall, 0);
    chk("bc.sticky", bad_code, 1);
    chk("bc.xfers", n_out - o0, 0);

    // reset during PRINT, ready low
    r2 = 32'd1; r4 = 32'h55; out_ready = 1'b0;
    o0 = n_out;
    run_sys("rs");
    chk("rs.c4_ov", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs.ov", out_valid, 0);
    chk("rs.stall", stall, 0);
    chk("rs.bad", bad_code, 0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("rs.ov2", out_valid, 0);
    chk("rs.xfers", n_out - o0, 0);

    // syscall together with reset
    reset = 1'b1; syscall = 1'b1;
    tick();
    reset = 1'b0; syscall = 1'b0;
    #1;
    chk("sr.sel", rf_sel, 0);
    chk("sr.stall", stall, 0);
    tick();
    chk("sr.addr", rf_rd_addr, 0);

    // exit
    r2 = 32'd10; o0 = n_out; w0 = n_we;
    run_sys("ex");
    chk("ex.c4_halt", halted, 1);
    chk("ex.c4_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      syscall = 1'b1;
      tick();
      syscall = 1'b0;
      chk("ex.halt", halted, 1);
      chk("ex.stall", stall, 1);
      chk("ex.sel", rf_sel, 0);
    end
    chk("ex.xfers", n_out - o0, 0);
    chk("ex.we", n_we - w0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ex.rst_halt", halted, 0);
    chk("ex.rst_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
